wb_select_pipe: RTL and testbench
=================================

# wb_select_pipe

Parametrised writeback-select stage for the pipelined CPU. Each accepted instruction is decoded into one writeback source: ALU result, load data, link address or zero-extended immediate. The block captures the selected value with its destination register and write enable in a 2-entry elastic buffer. A valid/ready handshake on both sides lets the register-file write port stall without losing results.

## Interface
- WIDTH, 16, datapath width of every data input and of out_data (≥ 8)
- AW, 3, destination-register index width, taken from ir[13:14-AW] (1..6)
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream presents an instruction and its operands
- in_ready  out  1  block can accept this cycle
- ir  in  16  instruction word
- d_alu  in  WIDTH  ALU result
- d_mem  in  WIDTH  data-memory read data
- pc_link  in  WIDTH  return address (PC+1)
- flush  in  1  discard all buffered entries
- out_valid  out  1  head entry valid
- out_ready  in  1  register file consumes head this cycle
- out_data  out  WIDTH  selected writeback value
- out_dest  out  AW  destination register
- out_we  out  1  register write enable
- out_kind  out  2  source used: 00 ALU, 01 MEM, 10 LINK, 11 IMM

## Operation
- Decode uses op = ir[15:14] and fn = ir[7:0]:
  - op==00, fn==8'h01: LD. Data is d_mem, kind 01, we 1.
  - op==00, fn==8'h02: JAL. Data is pc_link, kind 10, we 1. This applies only with WB_LINK_EN.
  - op==11: LI. Data is {(WIDTH-8) zeros, ir[7:0]}, kind 11, we 1.
  - op==10: branch/store. Data is d_alu, kind 00, we 0. The entry is still buffered and delivered.
  - Everything else is ALU: data d_alu, kind 00, we 1.
- dest = ir[13:14-AW] for every kind.
- Buffer has two entries, head and tail, with count in 0..2. in_ready = (count != 2), derived from registered count only.
- push = in_valid & in_ready & !flush. pop = out_valid & out_ready & !flush.
- count 0, push: the head loads the decoded entry.
- count 1:
  - push only: the tail loads.
  - pop only: count drops to 0.
  - push and pop together: the head loads the new entry and count stays 1.
- count 2:
  - pop: the head takes the tail and count drops to 1.
  - No push is possible while count is 2.
- flush clears count to 0 on the next edge. It overrides push and pop in the same cycle. Stale entry fields are not cleared.
- out_valid = (count != 0). out_* fields always show the head entry.

## Timing
- Reset values:
  - count 0, out_valid 0, out_data 0, out_dest 0, out_we 0, out_kind 00.
  - in_ready 1 while RST is asserted.
- Latency: an entry accepted at edge N (count 0) appears with out_valid=1 after edge N and is poppable at edge N+1.
- Throughput is one entry per cycle with out_ready held high.
- With out_ready low, two entries are accepted and in_ready drops to 0 after the second edge. It returns to 1 the cycle after the first pop.
- Holding rule: out_data, out_dest, out_we and out_kind are stable while out_valid=1 and out_ready=0.
- Operand sampling: ir, d_alu, d_mem and pc_link are sampled only at the push edge, so upstream may change them after acceptance.
- RST asserted mid-operation empties the buffer immediately (asynchronously). No entry is delivered after reset.

## Configuration
- WB_LINK_EN defined: the JAL decode (op 00, fn 02) selects pc_link with kind 10.
- WB_LINK_EN undefined: the pc_link port remains but is ignored. JAL decodes as ALU (d_alu, kind 00, we 1), and kind 10 never appears.

## Test plan
- Reset, then a single LD: ir=16'h0801, d_mem=16'hBEEF, d_alu=16'h1234, out_ready=1. Required: one cycle later out_valid=1, out_data=BEEF, out_dest=1, out_we=1, out_kind=01. out_valid returns to 0 the following cycle.
- LI with WIDTH=16: ir=16'hC0A5. Required: out_data=16'h00A5, kind 11, dest 0.
- Backpressure with out_ready=0:
  - Push ALU 16'h0001 then ALU 16'h0002 (ir op 01). Required: in_ready=0 after the second edge and a third in_valid is not accepted.
  - Then raise out_ready. Required: 0001 then 0002 on consecutive cycles, and in_ready=1 after the first pop.
- Branch ir=16'h8000 with d_alu=16'h5555. Required: delivered with out_we=0, kind 00.
- Flush with count=2, and flush asserted together with in_valid=1. Required: next cycle out_valid=0 and the input is not captured. Asserting RST with count=1 drops out_valid to 0 before the next edge.
- JAL ir=16'h0002 with pc_link=16'h0100 and d_alu=16'h7777. Required: with WB_LINK_EN, out_data=0100 and kind 10. Without it, out_data=7777 and kind 00.

Source files
------------

// File: rtl/wb_select_pipe.sv
// Writeback-select stage: decodes each accepted instruction into one writeback source and
// holds the result in a 2-entry elastic buffer. Define WB_LINK_EN to enable JAL link writeback.
module wb_select_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      ir,
  input  logic [WIDTH-1:0] d_alu,
  input  logic [WIDTH-1:0] d_mem,
  input  logic [WIDTH-1:0] pc_link,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    out_dest,
  output logic             out_we,
  output logic [1:0]       out_kind
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [AW-1:0]    dest;
    logic             we;
    logic [1:0]       kind;
  } entry_t;

  entry_t     head_q, head_d, tail_q, tail_d, dec;
  logic [1:0] count_q, count_d;
  logic       push, pop;
  logic [1:0] op;
  logic [7:0] fn;

  // Only some instruction bits feed the decode; fold the rest so none appear dangling.
  logic unused_ir;
  assign unused_ir = ^ir;

  assign op = ir[15:14];
  assign fn = ir[7:0];

  always_comb begin
    dec      = '0;
    dec.data = d_alu;
    dec.dest = ir[13 -: AW];
    dec.we   = 1'b1;
    dec.kind = 2'b00;
    if (op == 2'b00 && fn == 8'h01) begin
      dec.data = d_mem;
      dec.kind = 2'b01;
    end else if (op == 2'b11) begin
      dec.data = WIDTH'(fn);
      dec.kind = 2'b11;
    end else if (op == 2'b10) begin
      dec.we = 1'b0;
    end
`ifdef WB_LINK_EN
    else if (op == 2'b00 && fn == 8'h02) begin
      dec.data = pc_link;
      dec.kind = 2'b10;
    end
`endif
  end

`ifndef WB_LINK_EN
  logic unused_pc_link;
  assign unused_pc_link = ^pc_link;
`endif

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            head_d  = dec;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_d = dec;
          end else if (push) begin
            tail_d  = dec;
            count_d = 2'd2;
          end else if (pop) begin
            count_d = 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_d  = tail_q;
            count_d = 2'd1;
          end
        end
        default: count_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign out_data = head_q.data;
  assign out_dest = head_q.dest;
  assign out_we   = head_q.we;
  assign out_kind = head_q.kind;

endmodule

// File: tb/tb_wb_select_pipe.sv
// Directed bench for wb_select_pipe: per-instruction decode table plus flow-control sequences.
module tb_wb_select_pipe;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] ir = '0;
  logic [15:0] d_alu = '0;
  logic [15:0] d_mem = '0;
  logic [15:0] pc_link = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [2:0]  out_dest;
  logic        out_we;
  logic [1:0]  out_kind;

  int checks = 0;
  int errors = 0;

  wb_select_pipe #(.WIDTH(16), .AW(3)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ir        (ir),
    .d_alu     (d_alu),
    .d_mem     (d_mem),
    .pc_link   (pc_link),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_dest  (out_dest),
    .out_we    (out_we),
    .out_kind  (out_kind)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [15:0] ir;
    logic [15:0] d_alu;
    logic [15:0] d_mem;
    logic [15:0] pc_link;
    logic [15:0] exp_data;
    logic [2:0]  exp_dest;
    logic        exp_we;
    logic [1:0]  exp_kind;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_alu(input logic [15:0] v);
    in_valid = 1'b1;
    ir       = 16'h4000;
    d_alu    = v;
  endtask

  initial begin
    vecs[0] = '{"ld",     16'h0801, 16'h1234, 16'hBEEF, 16'h0000, 16'hBEEF, 3'd1, 1'b1, 2'b01};
    vecs[1] = '{"li",     16'hC0A5, 16'h1234, 16'h9999, 16'h0000, 16'h00A5, 3'd0, 1'b1, 2'b11};
    vecs[2] = '{"branch", 16'h8000, 16'h5555, 16'h9999, 16'h0000, 16'h5555, 3'd0, 1'b0, 2'b00};
`ifdef WB_LINK_EN
    vecs[3] = '{"jal",    16'h0002, 16'h7777, 16'h9999, 16'h0100, 16'h0100, 3'd0, 1'b1, 2'b10};
`else
    vecs[3] = '{"jal",    16'h0002, 16'h7777, 16'h9999, 16'h0100, 16'h7777, 3'd0, 1'b1, 2'b00};
`endif
    vecs[4] = '{"alu01",  16'h5803, 16'hABCD, 16'h9999, 16'h0100, 16'hABCD, 3'd3, 1'b1, 2'b00};
    vecs[5] = '{"alu00",  16'h3803, 16'h1111, 16'h9999, 16'h0100, 16'h1111, 3'd7, 1'b1, 2'b00};
    vecs[6] = '{"li_d7",  16'hF8FF, 16'h1111, 16'h9999, 16'h0100, 16'h00FF, 3'd7, 1'b1, 2'b11};
    vecs[7] = '{"st_d4",  16'hA012, 16'h2222, 16'h9999, 16'h0100, 16'h2222, 3'd4, 1'b0, 2'b00};

    // Reset state
    #2;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_dest", 32'(out_dest), 32'd0);
    check("rst_we", 32'(out_we), 32'd0);
    check("rst_kind", 32'(out_kind), 32'd0);
    tick();
    RST = 1'b0;
    tick();

    // Decode table, one instruction at a time with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      ir       = vecs[i].ir;
      d_alu    = vecs[i].d_alu;
      d_mem    = vecs[i].d_mem;
      pc_link  = vecs[i].pc_link;
      tick();
      in_valid = 1'b0;
      ir       = 16'hFFFF;
      d_alu    = 16'hDEAD;
      d_mem    = 16'hDEAD;
      pc_link  = 16'hDEAD;
      check({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
      check({vecs[i].name, "_data"}, 32'(out_data), 32'(vecs[i].exp_data));
      check({vecs[i].name, "_dest"}, 32'(out_dest), 32'(vecs[i].exp_dest));
      check({vecs[i].name, "_we"}, 32'(out_we), 32'(vecs[i].exp_we));
      check({vecs[i].name, "_kind"}, 32'(out_kind), 32'(vecs[i].exp_kind));
      tick();
      check({vecs[i].name, "_drain"}, 32'(out_valid), 32'd0);
    end

    // Full throughput: push and pop every cycle
    push_alu(16'h00A1);
    tick();
    check("tp_a", 32'(out_data), 32'h00A1);
    push_alu(16'h00B2);
    tick();
    check("tp_b", 32'(out_data), 32'h00B2);
    check("tp_b_ready", 32'(in_ready), 32'd1);
    push_alu(16'h00C3);
    tick();
    check("tp_c", 32'(out_data), 32'h00C3);
    in_valid = 1'b0;
    tick();
    check("tp_empty", 32'(out_valid), 32'd0);

    // Backpressure: fill both entries, third push refused
    out_ready = 1'b0;
    push_alu(16'h0001);
    tick();
    check("bp_ready1", 32'(in_ready), 32'd1);
    push_alu(16'h0002);
    tick();
    check("bp_ready2", 32'(in_ready), 32'd0);
    check("bp_head", 32'(out_data), 32'h0001);
    push_alu(16'h0003);
    tick();
    check("bp_hold_data", 32'(out_data), 32'h0001);
    check("bp_hold_ready", 32'(in_ready), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_second", 32'(out_data), 32'h0002);
    check("bp_second_valid", 32'(out_valid), 32'd1);
    check("bp_ready_back", 32'(in_ready), 32'd1);
    tick();
    check("bp_no_third", 32'(out_valid), 32'd0);

    // Flush with two entries buffered, then flush racing a push
    out_ready = 1'b0;
    push_alu(16'h0011);
    tick();
    push_alu(16'h0022);
    tick();
    in_valid = 1'b0;
    flush    = 1'b1;
    tick();
    check("fl_full_valid", 32'(out_valid), 32'd0);
    check("fl_full_ready", 32'(in_ready), 32'd1);
    push_alu(16'h0033);
    tick();
    check("fl_push_valid", 32'(out_valid), 32'd0);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    check("fl_after", 32'(out_valid), 32'd0);

    // Asynchronous reset with one entry buffered
    push_alu(16'h0044);
    tick();
    in_valid = 1'b0;
    check("ar_pre", 32'(out_valid), 32'd1);
    #1 RST = 1'b1;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_data", 32'(out_data), 32'd0);
    check("ar_ready", 32'(in_ready), 32'd1);
    tick();
    RST       = 1'b0;
    out_ready = 1'b1;
    tick();
    check("ar_after", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
